xmem_pair_seq: RTL and testbench

- Sequencer between the 1K x 24-bit input-image memory and the systolic alignment accelerator.
- On a start pulse, walks the memory from a base address and reads consecutive word pairs (xdata1 = even slot, xdata2 = odd slot).
- Presents each pair to the accelerator over a valid/ready handshake.
- Signals done after the programmed number of pairs has been accepted.

---
 rtl/xmem_pair_seq.sv | 211 +++++++++++++++++++++
 tb/tb_xmem_pair_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_pair_seq.sv
// Pair sequencer: reads consecutive word pairs from the image memory and hands
// them to the alignment accelerator over valid/ready. Optional run repeat: XMEM_PAIR_SEQ_LOOP_EN.
module xmem_pair_seq #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
`ifdef XMEM_PAIR_SEQ_LOOP_EN
   input  logic              loop,
`endif
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  pair_cnt,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] xdata1,
   output logic [DATA_W-1:0] xdata2,
   output logic              x_valid,
   input  logic              x_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_B  = 3'd2,
      CAP_B = 3'd3,
      OUT   = 3'd4,
      FIN   = 3'd5
   } state_t;

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] ptr_r, ptr_s;
   logic [CNT_W-1:0]  rem_r, rem_s;
   logic              mem_rd_en_r, mem_rd_en_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic [DATA_W-1:0] xdata1_r, xdata1_s;
   logic [DATA_W-1:0] xdata2_r, xdata2_s;
   logic              x_valid_r, x_valid_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
   logic [ADDR_W-1:0] base_lat_r, base_lat_s;
   logic [CNT_W-1:0]  cnt_lat_r, cnt_lat_s;
   logic              loop_pend_r, loop_pend_s;
`endif

   // Address arithmetic wraps naturally at the memory size.
   function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] inc);
      return a + inc;
   endfunction

   // Next-state and next-output computation; all outputs are registered below.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      rem_s       = rem_r;
      mem_rd_en_s = 1'b0;
      mem_addr_s  = mem_addr_r;
      xdata1_s    = xdata1_r;
      xdata2_s    = xdata2_r;
      x_valid_s   = 1'b0;
      busy_s      = busy_r;
      done_s      = 1'b0;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
      base_lat_s  = base_lat_r;
      cnt_lat_s   = cnt_lat_r;
      loop_pend_s = loop_pend_r;
`endif
      if (abort && (state_r != IDLE)) begin
         state_s = IDLE;
         busy_s  = 1'b0;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
         loop_pend_s = 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  ptr_s  = base_addr;
                  rem_s  = pair_cnt;
                  busy_s = 1'b1;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
                  base_lat_s  = base_addr;
                  cnt_lat_s   = pair_cnt;
                  loop_pend_s = 1'b0;
`endif
                  if (pair_cnt != {CNT_W{1'b0}}) begin
                     state_s     = RD_A;
                     mem_rd_en_s = 1'b1;
                     mem_addr_s  = base_addr;
                  end else begin
                     state_s = FIN;
                     done_s  = 1'b1;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            RD_A: begin
               state_s     = RD_B;
               mem_rd_en_s = 1'b1;
               mem_addr_s  = addr_add(ptr_r, ADDR_W'(1));
            end
            RD_B: begin
               state_s  = CAP_B;
               xdata1_s = mem_rdata;
            end
            CAP_B: begin
               state_s   = OUT;
               xdata2_s  = mem_rdata;
               x_valid_s = 1'b1;
            end
            OUT: begin
               if (x_ready) begin
                  ptr_s = addr_add(ptr_r, ADDR_W'(2));
                  rem_s = rem_r - CNT_W'(1);
                  if (rem_r != CNT_W'(1)) begin
                     state_s     = RD_A;
                     mem_rd_en_s = 1'b1;
                     mem_addr_s  = addr_add(ptr_r, ADDR_W'(2));
                  end else begin
                     state_s = FIN;
                     done_s  = 1'b1;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
                     loop_pend_s = loop;
`endif
                  end
               end else begin
                  x_valid_s = 1'b1;
               end
            end
            FIN: begin
`ifdef XMEM_PAIR_SEQ_LOOP_EN
               // A pending loop restarts from the latched run parameters.
               if (loop_pend_r) begin
                  state_s     = RD_A;
                  ptr_s       = base_lat_r;
                  rem_s       = cnt_lat_r;
                  mem_rd_en_s = 1'b1;
                  mem_addr_s  = base_lat_r;
                  loop_pend_s = 1'b0;
               end else begin
                  state_s = IDLE;
                  busy_s  = 1'b0;
               end
`else
               state_s = IDLE;
               busy_s  = 1'b0;
`endif
            end
            default: begin
               state_s = IDLE;
               busy_s  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= IDLE;
         ptr_r       <= {ADDR_W{1'b0}};
         rem_r       <= {CNT_W{1'b0}};
         mem_rd_en_r <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         xdata1_r    <= {DATA_W{1'b0}};
         xdata2_r    <= {DATA_W{1'b0}};
         x_valid_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
         base_lat_r  <= {ADDR_W{1'b0}};
         cnt_lat_r   <= {CNT_W{1'b0}};
         loop_pend_r <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         rem_r       <= rem_s;
         mem_rd_en_r <= mem_rd_en_s;
         mem_addr_r  <= mem_addr_s;
         xdata1_r    <= xdata1_s;
         xdata2_r    <= xdata2_s;
         x_valid_r   <= x_valid_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
         base_lat_r  <= base_lat_s;
         cnt_lat_r   <= cnt_lat_s;
         loop_pend_r <= loop_pend_s;
`endif
      end
   end

   assign mem_rd_en = mem_rd_en_r;
   assign mem_addr  = mem_addr_r;
   assign xdata1    = xdata1_r;
   assign xdata2    = xdata2_r;
   assign x_valid   = x_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_xmem_pair_seq.sv
// Directed bench for xmem_pair_seq: table of single-pair runs plus hand-written
// sequences for stall, wrap, zero count, abort, reset and (optionally) loop.
module tb_xmem_pair_seq;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        abort;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
   logic        loop;
`endif
   logic [9:0]  base_addr;
   logic [8:0]  pair_cnt;
   logic        mem_rd_en;
   logic [9:0]  mem_addr;
   logic [23:0] mem_rdata;
   logic [23:0] xdata1;
   logic [23:0] xdata2;
   logic        x_valid;
   logic        x_ready;
   logic        busy;
   logic        done;

   logic [23:0] mem [1024];

   int n_vec;
   int n_bad;
   int n_acc;
   int n_done;
   int n_rd;
   logic [23:0] acc1 [16];
   logic [23:0] acc2 [16];
   logic [9:0]  rd_log [16];

   typedef struct {
      logic [9:0]  base;
      logic [9:0]  addr_a;
      logic [9:0]  addr_b;
      logic [23:0] x1;
      logic [23:0] x2;
   } vec_t;
   vec_t vecs [4];

   xmem_pair_seq dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .abort     (abort),
`ifdef XMEM_PAIR_SEQ_LOOP_EN
      .loop      (loop),
`endif
      .base_addr (base_addr),
      .pair_cnt  (pair_cnt),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .xdata1    (xdata1),
      .xdata2    (xdata2),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory model: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear();
      n_acc  = 0;
      n_done = 0;
      n_rd   = 0;
   endtask

   // Record what happens in the current cycle, then advance to just after the next edge.
   task automatic step();
      @(negedge clk);
      if (x_valid && x_ready && !abort) begin
         if (n_acc < 16) begin
            acc1[n_acc] = xdata1;
            acc2[n_acc] = xdata2;
         end
         n_acc++;
      end
      if (done) n_done++;
      if (mem_rd_en) begin
         if (n_rd < 16) rd_log[n_rd] = mem_addr;
         n_rd++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 60 && busy; k++) step();
      chk(name, 32'(busy), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      clear();
      base_addr = v.base;
      pair_cnt  = 9'd1;
      x_ready   = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("vec_c1_rd_en", 32'(mem_rd_en), 32'd1);
      chk("vec_c1_addr", 32'(mem_addr), 32'(v.addr_a));
      chk("vec_c1_busy", 32'(busy), 32'd1);
      step();
      chk("vec_c2_rd_en", 32'(mem_rd_en), 32'd1);
      chk("vec_c2_addr", 32'(mem_addr), 32'(v.addr_b));
      step();
      chk("vec_c3_rd_en", 32'(mem_rd_en), 32'd0);
      chk("vec_c3_valid", 32'(x_valid), 32'd0);
      step();
      chk("vec_c4_valid", 32'(x_valid), 32'd1);
      chk("vec_c4_xdata1", 32'(xdata1), 32'(v.x1));
      chk("vec_c4_xdata2", 32'(xdata2), 32'(v.x2));
      chk("vec_c4_done", 32'(done), 32'd0);
      step();
      chk("vec_c5_valid", 32'(x_valid), 32'd0);
      chk("vec_c5_done", 32'(done), 32'd1);
      chk("vec_c5_busy", 32'(busy), 32'd1);
      step();
      chk("vec_c6_done", 32'(done), 32'd0);
      chk("vec_c6_busy", 32'(busy), 32'd0);
      chk("vec_c6_xdata1_hold", 32'(xdata1), 32'(v.x1));
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      clear();
      for (int i = 0; i < 1024; i++) mem[i] = 24'h100000 + 24'(i);
      mem[0] = 24'h00A1B2;
      mem[1] = 24'h00C3D4;
      mem_rdata = 24'h000000;

      vecs[0] = '{base: 10'd0,    addr_a: 10'd0,    addr_b: 10'd1,   x1: 24'h00A1B2, x2: 24'h00C3D4};
      vecs[1] = '{base: 10'd10,   addr_a: 10'd10,   addr_b: 10'd11,  x1: 24'h10000A, x2: 24'h10000B};
      vecs[2] = '{base: 10'd1023, addr_a: 10'd1023, addr_b: 10'd0,   x1: 24'h1003FF, x2: 24'h00A1B2};
      vecs[3] = '{base: 10'd511,  addr_a: 10'd511,  addr_b: 10'd512, x1: 24'h1001FF, x2: 24'h100200};

      rstn = 1'b0; start = 1'b0; abort = 1'b0; x_ready = 1'b1;
      base_addr = 10'd0; pair_cnt = 9'd0;
`ifdef XMEM_PAIR_SEQ_LOOP_EN
      loop = 1'b0;
`endif
      step();
      step();
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_xdata1", 32'(xdata1), 32'd0);
      chk("rst_xdata2", 32'(xdata2), 32'd0);
      chk("rst_valid", 32'(x_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rstn = 1'b1;
      step();

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Three pairs from 4 with a five-cycle stall on the second pair.
      clear();
      base_addr = 10'd4; pair_cnt = 9'd3; x_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 20 && n_acc < 1; k++) step();
      chk("stall_first_acc", 32'(n_acc), 32'd1);
      x_ready = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 20 && !x_valid; k++) step();
      start = 1'b0;
      chk("stall_valid", 32'(x_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_valid_hold", 32'(x_valid), 32'd1);
         chk("stall_x1_hold", 32'(xdata1), 32'h100006);
         chk("stall_x2_hold", 32'(xdata2), 32'h100007);
         chk("stall_no_rd", 32'(mem_rd_en), 32'd0);
      end
      x_ready = 1'b1;
      wait_idle("stall_idle");
      chk("stall_n_acc", 32'(n_acc), 32'd3);
      chk("stall_n_done", 32'(n_done), 32'd1);
      chk("stall_p0_x1", 32'(acc1[0]), 32'h100004);
      chk("stall_p0_x2", 32'(acc2[0]), 32'h100005);
      chk("stall_p1_x1", 32'(acc1[1]), 32'h100006);
      chk("stall_p1_x2", 32'(acc2[1]), 32'h100007);
      chk("stall_p2_x1", 32'(acc1[2]), 32'h100008);
      chk("stall_p2_x2", 32'(acc2[2]), 32'h100009);

      // Two pairs across the top of memory.
      clear();
      base_addr = 10'd1023; pair_cnt = 9'd2; start = 1'b1;
      step();
      start = 1'b0;
      wait_idle("wrap_idle");
      chk("wrap_n_rd", 32'(n_rd), 32'd4);
      chk("wrap_rd0", 32'(rd_log[0]), 32'd1023);
      chk("wrap_rd1", 32'(rd_log[1]), 32'd0);
      chk("wrap_rd2", 32'(rd_log[2]), 32'd1);
      chk("wrap_rd3", 32'(rd_log[3]), 32'd2);
      chk("wrap_p0_x1", 32'(acc1[0]), 32'h1003FF);
      chk("wrap_p0_x2", 32'(acc2[0]), 32'h00A1B2);
      chk("wrap_p1_x1", 32'(acc1[1]), 32'h00C3D4);
      chk("wrap_p1_x2", 32'(acc2[1]), 32'h100002);

      // Zero pair count: immediate completion, start during busy ignored.
      clear();
      base_addr = 10'd8; pair_cnt = 9'd0; start = 1'b1;
      step();
      chk("zero_c1_done", 32'(done), 32'd1);
      chk("zero_c1_busy", 32'(busy), 32'd1);
      chk("zero_c1_rd_en", 32'(mem_rd_en), 32'd0);
      pair_cnt = 9'd1;
      step();
      start = 1'b0;
      chk("zero_c2_done", 32'(done), 32'd0);
      chk("zero_c2_busy", 32'(busy), 32'd0);
      step();
      chk("zero_c3_busy", 32'(busy), 32'd0);
      chk("zero_n_rd", 32'(n_rd), 32'd0);

      // Abort while a pair is offered and accepted in the same cycle.
      clear();
      base_addr = 10'd0; pair_cnt = 9'd2; x_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      chk("abort_c4_valid", 32'(x_valid), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_valid", 32'(x_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
      chk("abort_x1_hold", 32'(xdata1), 32'h00A1B2);
      step();
      chk("abort_still_idle", 32'(mem_rd_en), 32'd0);
      chk("abort_no_done", 32'(n_done), 32'd0);
      run_vec(vecs[1]);

      // Asynchronous reset in the middle of a run.
      clear();
      base_addr = 10'd4; pair_cnt = 9'd3; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      chk("mid_valid_pre", 32'(x_valid), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(x_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_xdata1", 32'(xdata1), 32'd0);
      chk("mid_rst_xdata2", 32'(xdata2), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      step();
      rstn = 1'b1;
      step();
      chk("mid_rst_after_busy", 32'(busy), 32'd0);

`ifdef XMEM_PAIR_SEQ_LOOP_EN
      // Looping run of one pair, then loop dropped.
      clear();
      base_addr = 10'd2; pair_cnt = 9'd1; loop = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 13; k++) step();
      chk("loop_busy_mid", 32'(busy), 32'd1);
      chk("loop_valid_c14", 32'(x_valid), 32'd1);
      loop = 1'b0;
      wait_idle("loop_idle");
      chk("loop_n_acc", 32'(n_acc), 32'd3);
      chk("loop_n_done", 32'(n_done), 32'd3);
      for (int k = 0; k < 3; k++) begin
         chk("loop_x1", 32'(acc1[k]), 32'h100002);
         chk("loop_x2", 32'(acc2[k]), 32'h100003);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
